// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink-rate controller: FSM encoding,
// rate-select codes and default half-periods (in clk cycles).
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [1:0] SEL_25 = 2'b00;
  localparam logic [1:0] SEL_10 = 2'b01;
  localparam logic [1:0] SEL_5  = 2'b10;
  localparam logic [1:0] SEL_1  = 2'b11;

  localparam int DEF_HALF_25 = 500;
  localparam int DEF_HALF_10 = 1250;
  localparam int DEF_HALF_5  = 2500;
  localparam int DEF_HALF_1  = 12500;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level input; both flops clear
// on reset so the synchronized value starts at 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  // Capture the raw input, then re-register to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// LED blink controller: one half-period counter plus the LED toggle flop.
// A requested rate change is held pending and applied only at the wrap that
// ends a high phase, so every high and low phase is a whole half-period.
module blink_rate_ctrl
  import blink_pkg::*;
#(
  parameter int HALF_25 = DEF_HALF_25,
  parameter int HALF_10 = DEF_HALF_10,
  parameter int HALF_5  = DEF_HALF_5,
  parameter int HALF_1  = DEF_HALF_1,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       s1,
  input  logic       s2,
  output logic       led,
  output logic [1:0] rate_idx,
  output logic       pending
);

  // Terminal count (half-1) for each rate.
  localparam logic [CNT_W-1:0] LAST_25 = CNT_W'(HALF_25 - 1);
  localparam logic [CNT_W-1:0] LAST_10 = CNT_W'(HALF_10 - 1);
  localparam logic [CNT_W-1:0] LAST_5  = CNT_W'(HALF_5 - 1);
  localparam logic [CNT_W-1:0] LAST_1  = CNT_W'(HALF_1 - 1);

  logic             en_s;
  logic             s1_s;
  logic             s2_s;
  logic [1:0]       sel_s;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             tog;
  logic             tog_nx;
  logic [1:0]       rate_nx;
  logic             pend_nx;

  logic [CNT_W-1:0] last;
  logic             wrap;
  logic [CNT_W-1:0] cnt_adv;
  logic             tog_adv;

  sync2 u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (en),
    .q     (en_s)
  );

  sync2 u_sync_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (s1),
    .q     (s1_s)
  );

  sync2 u_sync_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (s2),
    .q     (s2_s)
  );

  assign sel_s = {s2_s, s1_s};
  assign led   = tog;

  // Terminal count of the currently applied rate.
  always_comb begin
    last = LAST_25;
    case (rate_idx)
      SEL_25:  last = LAST_25;
      SEL_10:  last = LAST_10;
      SEL_5:   last = LAST_5;
      SEL_1:   last = LAST_1;
      default: last = LAST_25;
    endcase
  end

  // Ordinary count step: wrap to 0 and flip the LED, otherwise increment.
  always_comb begin
    wrap    = (cnt == last);
    cnt_adv = cnt + CNT_W'(1);
    tog_adv = tog;
    if (wrap) begin
      cnt_adv = '0;
      tog_adv = ~tog;
    end
  end

  // Next-state logic; losing the enable overrides any wrap or rate change.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tog_nx   = tog;
    rate_nx  = rate_idx;
    pend_nx  = pending;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        tog_nx  = 1'b0;
        pend_nx = 1'b0;
        rate_nx = sel_s;
        if (en_s) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!en_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          tog_nx   = 1'b0;
          pend_nx  = 1'b0;
        end else begin
          cnt_nx = cnt_adv;
          tog_nx = tog_adv;
          if (sel_s != rate_idx) begin
            pend_nx  = 1'b1;
            state_nx = PEND;
          end
        end
      end
      PEND: begin
        if (!en_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          tog_nx   = 1'b0;
          pend_nx  = 1'b0;
        end else if (sel_s == rate_idx) begin
          // Request withdrawn: keep counting undisturbed.
          cnt_nx   = cnt_adv;
          tog_nx   = tog_adv;
          pend_nx  = 1'b0;
          state_nx = RUN;
        end else if (wrap && tog) begin
          // End of a high phase: safe point to switch rates.
          cnt_nx   = '0;
          tog_nx   = 1'b0;
          rate_nx  = sel_s;
          pend_nx  = 1'b0;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt_adv;
          tog_nx = tog_adv;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        tog_nx   = 1'b0;
        pend_nx  = 1'b0;
      end
    endcase
  end

  // State, counter, LED flop and rate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tog      <= 1'b0;
      rate_idx <= SEL_25;
      pending  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      tog      <= tog_nx;
      rate_idx <= rate_nx;
      pending  <= pend_nx;
    end
  end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl with short half-periods.
module tb_blink_rate_ctrl;

  localparam int H25 = 4;
  localparam int H10 = 6;
  localparam int H5  = 8;
  localparam int H1  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       s1;
  logic       s2;
  logic       led;
  logic [1:0] rate_idx;
  logic       pending;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  blink_rate_ctrl #(
    .HALF_25 (H25),
    .HALF_10 (H10),
    .HALF_5  (H5),
    .HALF_1  (H1),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .s1       (s1),
    .s2       (s2),
    .led      (led),
    .rate_idx (rate_idx),
    .pending  (pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until led changes from its current value (bounded).
  task automatic wait_toggle(output int n);
    logic cur;
    cur = led;
    n = 0;
    do begin
      tick();
      n++;
    end while (led === cur && n < 200);
  endtask

  // Return to IDLE, load a rate select, then enable.
  task automatic start_at(input logic [1:0] sel);
    en = 1'b0;
    repeat (3) tick();
    {s2, s1} = sel;
    repeat (3) tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    int want;
    rst_n = 1'b0;
    en = 1'b1;
    {s2, s1} = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led: got %b want 0", led); end
    n_cmp++;
    if (rate_idx !== 2'b00) begin n_bad++; $display("FAIL reset_rate: got %b want 00", rate_idx); end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", pending); end
    rst_n = 1'b1;
    exp_q.push_back(3 + H25);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL reset_first_rise: got %0d cycles want %0d", n, want); end
    n_cmp++;
    if (led !== 1'b1) begin n_bad++; $display("FAIL reset_rise_level: got %b want 1", led); end
    repeat (4) exp_q.push_back(H25);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL reset_phase: got %0d cycles want %0d", n, want); end
    end
  endtask

  task automatic test_rate(input logic [1:0] sel, input int half);
    int n;
    int want;
    start_at(sel);
    n_cmp++;
    if (rate_idx !== sel) begin n_bad++; $display("FAIL rate_idx_%b: got %b want %b", sel, rate_idx, sel); end
    exp_q.push_back(3 + half);
    repeat (4) exp_q.push_back(half);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL rate_phase_%b: got %0d cycles want %0d", sel, n, want); end
    end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL rate_pending_%b: got %b want 0", sel, pending); end
  endtask

  task automatic test_deferred();
    int n;
    int want;
    start_at(2'b00);
    exp_q.push_back(3 + H25);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL defer_first_rise: got %0d want %0d", n, want); end
    tick();
    {s2, s1} = 2'b11;
    exp_q.push_back(H25);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (1 + n !== want) begin n_bad++; $display("FAIL defer_high0: got %0d cycles want %0d", 1 + n, want); end
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL defer_pending_set: got %b want 1", pending); end
    n_cmp++;
    if (rate_idx !== 2'b00) begin n_bad++; $display("FAIL defer_rate_held: got %b want 00", rate_idx); end
    exp_q.push_back(H25);
    exp_q.push_back(H25);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL defer_low1: got %0d cycles want %0d", n, want); end
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL defer_high1: got %0d cycles want %0d", n, want); end
    n_cmp++;
    if (rate_idx !== 2'b11) begin n_bad++; $display("FAIL defer_rate_applied: got %b want 11", rate_idx); end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL defer_pending_clr: got %b want 0", pending); end
    repeat (3) exp_q.push_back(H1);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL defer_new_phase: got %0d cycles want %0d", n, want); end
    end
  endtask

  task automatic test_cancel();
    int  n;
    int  want;
    logic seen;
    start_at(2'b01);
    exp_q.push_back(3 + H10);
    exp_q.push_back(H10);
    repeat (2) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL cancel_lead_phase: got %0d want %0d", n, want); end
    end
    {s2, s1} = 2'b10;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (pending === 1'b1) seen = 1'b1;
    end
    {s2, s1} = 2'b01;
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL cancel_pending_rise: got %b want 1", seen); end
    exp_q.push_back(H10);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (5 + n !== want) begin n_bad++; $display("FAIL cancel_low: got %0d cycles want %0d", 5 + n, want); end
    repeat (2) exp_q.push_back(H10);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL cancel_phase: got %0d cycles want %0d", n, want); end
    end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL cancel_pending_fall: got %b want 0", pending); end
    n_cmp++;
    if (rate_idx !== 2'b01) begin n_bad++; $display("FAIL cancel_rate: got %b want 01", rate_idx); end
  endtask

  task automatic test_enable_drop();
    int n;
    int want;
    start_at(2'b11);
    exp_q.push_back(3 + H1);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL endrop_first_rise: got %0d want %0d", n, want); end
    {s2, s1} = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL endrop_pending_set: got %b want 1", pending); end
    en = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (led !== 1'b1) begin n_bad++; $display("FAIL endrop_led_hold: got %b want 1", led); end
    tick();
    n_cmp++;
    if (led !== 1'b0) begin n_bad++; $display("FAIL endrop_led_off: got %b want 0", led); end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL endrop_pending_clr: got %b want 0", pending); end
    tick();
    n_cmp++;
    if (rate_idx !== 2'b00) begin n_bad++; $display("FAIL endrop_idle_rate: got %b want 00", rate_idx); end
    repeat (3) tick();
    n_cmp++;
    if (led !== 1'b0) begin n_bad++; $display("FAIL endrop_idle_led: got %b want 0", led); end
    en = 1'b1;
    exp_q.push_back(3 + H25);
    repeat (2) exp_q.push_back(H25);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL endrop_restart: got %0d cycles want %0d", n, want); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    int want;
    start_at(2'b01);
    exp_q.push_back(3 + H10);
    wait_toggle(n);
    want = exp_q.pop_front();
    n_cmp++;
    if (n !== want) begin n_bad++; $display("FAIL arst_first_rise: got %0d want %0d", n, want); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== 1'b0) begin n_bad++; $display("FAIL arst_led: got %b want 0", led); end
    n_cmp++;
    if (rate_idx !== 2'b00) begin n_bad++; $display("FAIL arst_rate: got %b want 00", rate_idx); end
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL arst_pending: got %b want 0", pending); end
    #2;
    rst_n = 1'b1;
    exp_q.push_back(3 + H10);
    repeat (2) exp_q.push_back(H10);
    while (exp_q.size() > 0) begin
      wait_toggle(n);
      want = exp_q.pop_front();
      n_cmp++;
      if (n !== want) begin n_bad++; $display("FAIL arst_restart: got %0d cycles want %0d", n, want); end
    end
    n_cmp++;
    if (rate_idx !== 2'b01) begin n_bad++; $display("FAIL arst_rate_restart: got %b want 01", rate_idx); end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    s1 = 1'b0;
    s2 = 1'b0;
    test_reset();
    test_rate(2'b11, H1);
    test_rate(2'b01, H10);
    test_rate(2'b10, H5);
    test_deferred();
    test_cancel();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
Controller for the LED frequency-scaling datapath. It owns one programmable half-period counter and the LED toggle flop. It selects one of four blink rates from the s1/s2 switches and gates the output with en. Rate changes are deferred to the end of a high phase, so the LED never produces a runt pulse. It sits between the board switches/clock and the LED pin.

Parameters:
HALF_25, 500, half-period in clk cycles for the fastest rate (sel 00)
HALF_10, 1250, half-period for sel 01
HALF_5, 2500, half-period for sel 10
HALF_1, 12500, half-period for the slowest rate (sel 11)
CNT_W, 16, counter width; must hold max(HALF_*)-1; every HALF_* >= 2

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous, active-low reset
en  input  1  asynchronous switch, LED enable
s1  input  1  asynchronous switch, rate select bit 0
s2  input  1  asynchronous switch, rate select bit 1
led  output  1  blink output, driven directly from the toggle flop
rate_idx  output  2  currently applied rate select
pending  output  1  a rate change is requested but not yet applied

Behaviour:
- Reset (rst_n=0, async): state=IDLE, counter=0, toggle=0, led=0, rate_idx=00, pending=0, synchronizer flops=0.
- en, s1 and s2 each pass through a 2-flop synchronizer, giving en_s and sel_s={s2_s,s1_s}. Input-to-sync latency is 2 cycles.
- half = HALF_x selected by rate_idx. A counter wrap means counter==half-1: counter<=0 and toggle<=~toggle. Otherwise counter<=counter+1.
- IDLE: counter=0, toggle=0, rate_idx<=sel_s every cycle. When en_s=1, go to RUN with counter=0 and toggle=0. The first rise of led occurs `half` cycles after entering RUN.
- RUN: normal counting and wrapping. If sel_s!=rate_idx, set pending<=1 and go to PEND. Counting continues in the same cycle.
- PEND: keep counting at the old rate.
  - If sel_s==rate_idx, cancel: pending<=0, return to RUN, no disturbance to the counter.
  - Wrap with toggle=0: normal toggle to 1, stay in PEND.
  - Wrap with toggle=1: toggle<=0, counter<=0, rate_idx<=sel_s (latest value at that cycle), pending<=0, go to RUN.
  - If sel_s changes again while in PEND, the latest value is applied.
- en_s=0 in RUN or PEND: next cycle state=IDLE, toggle=0, led=0, counter=0, pending=0. This takes priority over any wrap or rate change in the same cycle.
- led high and low phases are always exactly `half` cycles of the applied rate. A phase never shortens across a rate change.
- The counter never exceeds half-1. There is no overflow path.
- rst_n asserted mid-phase aborts immediately to the reset values. Operation restarts from IDLE after deassertion.

Decomposition:
- Shared package blink_pkg:
  - state encoding IDLE=0, RUN=1, PEND=2
  - 2-bit rate-select constants SEL_25=00, SEL_10=01, SEL_5=10, SEL_1=11
  - default half-period constants
- One sub-module, sync2: a 2-flop synchronizer with async active-low reset to 0. It is instantiated three times (en, s1, s2).
- The counter, FSM and toggle stay in blink_rate_ctrl.

Test Plan:
Every scenario uses HALF_25=4, HALF_10=6, HALF_5=8, HALF_1=10.
- Reset: rst_n=0 for 3 cycles with en=1 -> led=0, rate_idx=00, pending=0. Release with sel 00, en=1 -> led rises 2 (sync) + 1 (IDLE->RUN) + 4 cycles later; then 4 high / 4 low, repeating.
- Rate per select: sel=11, en=1 -> rate_idx=11, led period 20 cycles with 50% duty. Repeat for sel 01 (period 12) and sel 10 (period 16).
- Deferred change: running at sel 00, switch to 11 mid-high-phase -> pending=1 within 3 cycles. The high phase still lasts exactly 4 cycles, the next low phase is 4 cycles, then the following high phase lasts 4 cycles. At the wrap ending that high phase, rate_idx=11 and pending=0, and subsequent phases are 10 cycles.
- Cancel: at sel 01, pulse sel to 10 for 5 cycles within one phase -> pending rises then falls. rate_idx stays 01 and the phase lengths stay 6 throughout.
- Enable drop: deassert en mid-high-phase while pending=1 -> 3 cycles later led=0, pending=0, state IDLE. Re-assert en -> a clean restart with the first high phase after a full half-period.
- Async reset mid-operation: pulse rst_n low for under 1 cycle between clock edges -> led=0 immediately (no clock edge needed), then a normal restart.
